// File: rtl/nx_fifo_pkg.sv
// Shared types and helpers for the nx_fifo_flow buffering stage.
package nx_fifo_pkg;

  localparam int NX_FIFO_MAX_DEPTH = 1024;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
  } nx_fifo_status_t;

  function automatic int nx_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/nx_fifo_flow_ctrl.sv
// Pointer, occupancy, flag and high-water-mark control for an arbitrary-depth FIFO.
module nx_fifo_flow_ctrl
  import nx_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = nx_cnt_w(DEPTH),
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            wr_valid,
  input  logic            rd_ready,
  input  logic [CW-1:0]   afull_thresh,
  input  logic [CW-1:0]   aempty_thresh,
  output logic            push,
  output logic            pop,
  output logic [PW-1:0]   wptr,
  output logic [PW-1:0]   rptr,
  output logic [CW-1:0]   used,
  output logic [CW-1:0]   hwm,
  output nx_fifo_status_t status
);

  logic [PW-1:0] wptr_r, rptr_r;
  logic [CW-1:0] used_r, hwm_r, next_used_s;
  logic          empty_s, full_s;

  assign empty_s = (used_r == CW'(0));
  assign full_s  = (used_r == CW'(DEPTH));
  assign push    = wr_valid && !full_s;
  assign pop     = rd_ready && !empty_s;

  // occupancy after this cycle's accepted push/pop
  always_comb begin
    next_used_s = used_r;
    case ({push, pop})
      2'b10:   next_used_s = used_r + CW'(1);
      2'b01:   next_used_s = used_r - CW'(1);
      default: next_used_s = used_r;
    endcase
  end

  // pointer, count and high-water-mark registers; wrap by compare, not modulo
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wptr_r <= PW'(0);
      rptr_r <= PW'(0);
      used_r <= CW'(0);
      hwm_r  <= CW'(0);
    end else begin
      if (push) wptr_r <= (wptr_r == PW'(DEPTH - 1)) ? PW'(0) : wptr_r + PW'(1);
      if (pop)  rptr_r <= (rptr_r == PW'(DEPTH - 1)) ? PW'(0) : rptr_r + PW'(1);
      used_r <= next_used_s;
      if (next_used_s > hwm_r) hwm_r <= next_used_s;
    end
  end

  assign wptr = wptr_r;
  assign rptr = rptr_r;
  assign used = used_r;
  assign hwm  = hwm_r;

  assign status.empty        = empty_s;
  assign status.full         = full_s;
  assign status.almost_full  = (used_r >= afull_thresh);
  assign status.almost_empty = (used_r <= aempty_thresh);

endmodule

// File: rtl/nx_fifo_flow.sv
// First-word-fall-through valid/ready FIFO with thresholds and high-water mark.
// Optional per-entry even parity when NX_FIFO_PARITY_EN is defined.
module nx_fifo_flow
  import nx_fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int WIDTH      = 32,
  parameter int DATA_RESET = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [WIDTH-1:0]            wr_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [WIDTH-1:0]            rd_data,
  input  logic [nx_cnt_w(DEPTH)-1:0]  afull_thresh,
  input  logic [nx_cnt_w(DEPTH)-1:0]  aempty_thresh,
  output logic [nx_cnt_w(DEPTH)-1:0]  used_slots,
  output logic [nx_cnt_w(DEPTH)-1:0]  free_slots,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [nx_cnt_w(DEPTH)-1:0]  hwm,
  output logic                        parity_err,
  output logic                        parity_err_sticky
);

  localparam int CW = nx_cnt_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef NX_FIFO_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif

  logic [EW-1:0]   mem_r [DEPTH];
  logic [EW-1:0]   entry_s;
  logic            push_s, pop_s;
  logic [PW-1:0]   wptr_s, rptr_s;
  logic [CW-1:0]   used_s, hwm_s;
  nx_fifo_status_t status_s;

  nx_fifo_flow_ctrl #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .PW    (PW)
  ) u_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .wr_valid      (wr_valid),
    .rd_ready      (rd_ready),
    .afull_thresh  (afull_thresh),
    .aempty_thresh (aempty_thresh),
    .push          (push_s),
    .pop           (pop_s),
    .wptr          (wptr_s),
    .rptr          (rptr_s),
    .used          (used_s),
    .hwm           (hwm_s),
    .status        (status_s)
  );

`ifdef NX_FIFO_PARITY_EN
  function automatic logic nx_even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  logic par_bad_s;
  logic parity_err_r, parity_err_sticky_r;

  assign entry_s   = {nx_even_par(wr_data), wr_data};
  assign par_bad_s = pop_s && (^mem_r[rptr_s]);

  // parity pulse one cycle after a bad pop; sticky until reset or clear
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      parity_err_r        <= 1'b0;
      parity_err_sticky_r <= 1'b0;
    end else begin
      parity_err_r        <= par_bad_s;
      parity_err_sticky_r <= parity_err_sticky_r | par_bad_s;
    end
  end

  assign parity_err        = parity_err_r;
  assign parity_err_sticky = parity_err_sticky_r;
`else
  assign entry_s           = wr_data;
  assign parity_err        = 1'b0;
  assign parity_err_sticky = 1'b0;
`endif

  // storage array; clear leaves contents alone and discards a same-cycle push
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (DATA_RESET != 0) begin
        for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      end
    end else if (!clear && push_s) begin
      mem_r[wptr_s] <= entry_s;
    end
  end

  assign rd_data      = status_s.empty ? WIDTH'(0) : mem_r[rptr_s][WIDTH-1:0];
  assign rd_valid     = !status_s.empty;
  assign wr_ready     = !status_s.full;
  assign empty        = status_s.empty;
  assign full         = status_s.full;
  assign almost_full  = status_s.almost_full;
  assign almost_empty = status_s.almost_empty;
  assign used_slots   = used_s;
  assign free_slots   = CW'(DEPTH) - used_s;
  assign hwm          = hwm_s;

endmodule

// File: tb/tb_nx_fifo_flow.sv
// Directed self-checking bench for nx_fifo_flow at DEPTH=5, WIDTH=8.
module tb_nx_fifo_flow;

  logic       clk = 1'b0;
  logic       rst_n, clear, wr_valid, rd_ready;
  logic [7:0] wr_data, rd_data;
  logic       wr_ready, rd_valid;
  logic [2:0] afull_thresh, aempty_thresh, used_slots, free_slots, hwm;
  logic       empty, full, almost_full, almost_empty, parity_err, parity_err_sticky;

  int n_checks = 0;
  int n_errs   = 0;

  nx_fifo_flow #(.DEPTH(5), .WIDTH(8), .DATA_RESET(0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
    .used_slots(used_slots), .free_slots(free_slots),
    .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
    .hwm(hwm), .parity_err(parity_err), .parity_err_sticky(parity_err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = 8'h00;
    afull_thresh = 3'd4; aempty_thresh = 3'd1;
    step(); step();
    rst_n = 1'b1;

    chk("rst_used", used_slots, 0);
    chk("rst_free", free_slots, 5);
    chk("rst_hwm", hwm, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_sticky", parity_err_sticky, 0);

    // FWFT latency: not visible in the push cycle, visible the next
    wr_valid = 1'b1; wr_data = 8'hA5;
    chk("lat_valid_n", rd_valid, 0);
    step();
    wr_valid = 1'b0;
    chk("lat_valid_n1", rd_valid, 1);
    chk("lat_data_n1", rd_data, 8'hA5);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("lat_drain_empty", empty, 1);
    chk("lat_hwm", hwm, 1);

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr0_hwm", hwm, 0);
    chk("fill_ae_0", almost_empty, 1);
    chk("fill_af_0", almost_full, 0);

    // fill 0x11..0x15 back to back, checking thresholds at each level
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 8'h11 + 8'(i);
      step();
      chk($sformatf("fill_used_%0d", i + 1), used_slots, i + 1);
      chk($sformatf("fill_ae_%0d", i + 1), almost_empty, (i + 1) <= 1);
      chk($sformatf("fill_af_%0d", i + 1), almost_full, (i + 1) >= 4);
    end
    chk("full_flag", full, 1);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_free", free_slots, 0);
    chk("full_hwm", hwm, 5);
    wr_data = 8'h99;
    step();
    wr_valid = 1'b0;
    chk("full_push_blocked", used_slots, 5);

    afull_thresh = 3'd0; #1;
    chk("af_thresh0", almost_full, 1);
    afull_thresh = 3'd6; #1;
    chk("af_thresh_gt_depth", almost_full, 0);
    afull_thresh = 3'd4;

    for (int i = 0; i < 5; i++) begin
      rd_ready = 1'b1;
      chk($sformatf("pop_data_%0d", i), rd_data, 8'h11 + i);
      step();
    end
    rd_ready = 1'b0;
    chk("pop_empty", empty, 1);
    chk("pop_rd_data_zero", rd_data, 0);

    // two entries, then 12 sustained push/pop pairs across pointer wraps
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = 8'h20 + 8'(i);
      step();
    end
    for (int k = 0; k < 12; k++) begin
      wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 8'h22 + 8'(k);
      chk($sformatf("sus_data_%0d", k), rd_data, 8'h20 + k);
      step();
      chk($sformatf("sus_used_%0d", k), used_slots, 2);
    end
    rd_ready = 1'b0;
    wr_data = 8'h40;
    step();
    chk("pre_clr_used", used_slots, 3);

    // clear with a concurrent write: the write is dropped
    clear = 1'b1; wr_valid = 1'b1; wr_data = 8'h55;
    step();
    clear = 1'b0; wr_valid = 1'b0;
    chk("clr_used", used_slots, 0);
    chk("clr_empty", empty, 1);
    chk("clr_hwm", hwm, 0);
    step();
    chk("clr_write_dropped", rd_valid, 0);

    wr_valid = 1'b1; wr_data = 8'h77;
    step();
    wr_valid = 1'b0; rd_ready = 1'b1;
    chk("post_clr_data", rd_data, 8'h77);
    step();
    rd_ready = 1'b0;
    chk("post_clr_perr", parity_err, 0);

`ifdef NX_FIFO_PARITY_EN
    wr_valid = 1'b1; wr_data = 8'h3C;
    step();
    wr_valid = 1'b0;
    dut.mem_r[1][2] = ~dut.mem_r[1][2];
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("par_pulse", parity_err, 1);
    chk("par_sticky", parity_err_sticky, 1);
    step();
    chk("par_pulse_end", parity_err, 0);
    chk("par_sticky_hold", parity_err_sticky, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("par_sticky_clr", parity_err_sticky, 0);
`else
    chk("nopar_sticky", parity_err_sticky, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/nx_fifo_flow.md
Name: nx_fifo_flow

Overview:
- Generalised successor to the team's basic synchronous FIFO.
- Arbitrary DEPTH (not restricted to a power of two) and WIDTH.
- Valid/ready handshakes on both sides; read side is first-word-fall-through.
- Adds programmable almost-full/almost-empty thresholds and a high-water-mark monitor.
- Used as the standard buffering stage between pipeline stages in the datapath.

Parameters:
- DEPTH, 8, number of entries; legal range 2..1024; need not be 2^n.
- WIDTH, 32, data word width in bits.
- DATA_RESET, 0, 1 = storage array is zeroed on reset; 0 = array is not reset.
- CW, $clog2(DEPTH+1), derived count width; not user-overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- clear  in  1  synchronous flush; empties the FIFO
- wr_valid  in  1  write request
- wr_ready  out  1  space available (= !full)
- wr_data  in  WIDTH  write data
- rd_valid  out  1  head word valid (= !empty)
- rd_ready  in  1  consumer accepts head word
- rd_data  out  WIDTH  head word
- afull_thresh  in  CW  almost-full threshold
- aempty_thresh  in  CW  almost-empty threshold
- used_slots  out  CW  current occupancy
- free_slots  out  CW  DEPTH - used_slots
- empty, full, almost_full, almost_empty  out  1 each  status flags
- hwm  out  CW  maximum occupancy since reset/clear
- parity_err  out  1  single-cycle parity error pulse
- parity_err_sticky  out  1  latched parity error

Behaviour:
- All state updates on posedge clk.
- Reset: rst_n=0 sampled at a clock edge gives the following state.
  - used_slots=0, free_slots=DEPTH, hwm=0.
  - empty=1, full=0, wr_ready=1, rd_valid=0, rd_data=0.
  - parity_err=0, parity_err_sticky=0.
  - Pointers are 0.
  - Reset overrides clear and all traffic in the same cycle.
- Push: wr_valid && wr_ready. Word is written at wptr.
- Pop: rd_valid && rd_ready. rptr advances.
- Pointer wrap: each pointer wraps from DEPTH-1 to 0 by explicit compare, with no modulo-2^n assumption.
- Latency: a word pushed in cycle N is visible on rd_data with rd_valid=1 in cycle N+1. There is no same-cycle bypass.
- rd_data is the head entry when rd_valid=1 and is forced to 0 when empty.
- Count update: used += push - pop.
  - Simultaneous push and pop leaves the count unchanged; both pointers advance.
- Full: wr_ready=0, so no push is possible. A pop in the same cycle frees a slot for the next cycle.
- Empty: rd_valid=0, so no pop is possible.
- Flags are combinational from the registered count.
  - empty = (used==0); full = (used==DEPTH).
  - almost_full = (used >= afull_thresh).
  - almost_empty = (used <= aempty_thresh).
  - Threshold inputs are sampled continuously and may change at any time.
- Threshold boundary cases:
  - afull_thresh=0 gives almost_full permanently 1.
  - afull_thresh > DEPTH gives almost_full permanently 0.
- hwm register: loaded with next_used whenever next_used > hwm.
- clear, when high at an edge with rst_n=1:
  - Pointers, count and hwm go to 0; the next cycle shows empty.
  - clear overrides any push or pop in that cycle; a push in that cycle is discarded.
  - parity_err_sticky is cleared.
  - The storage array is untouched.
- All arithmetic is unsigned at CW bits. No overflow is possible by construction.

Optional Feature:
- Macro: NX_FIFO_PARITY_EN.
- When defined:
  - Each entry stores WIDTH+1 bits; the extra bit is the even parity of wr_data.
  - On every pop, the parity of the head entry is checked.
  - A mismatch produces parity_err=1 in the cycle after the pop (registered).
  - A mismatch sets parity_err_sticky, which is cleared only by rst_n or clear.
- When undefined:
  - The array is WIDTH bits.
  - parity_err and parity_err_sticky are tied to 0.
  - Ports remain present.

Decomposition:
- Package nx_fifo_pkg holds:
  - function nx_cnt_w(depth) returning $clog2(depth+1).
  - typedef nx_fifo_status_t, a packed struct of {empty, full, almost_full, almost_empty}.
  - localparam NX_FIFO_MAX_DEPTH=1024.
- Sub-module nx_fifo_flow_ctrl holds the pointers, count, flags and hwm for arbitrary DEPTH.
- The top level holds the storage array and the parity logic.

Test Plan:
- DEPTH=5, WIDTH=8: push 0x11..0x15 on back-to-back cycles -> full=1 and wr_ready=0 after 5th push; used_slots=5, free_slots=0, hwm=5; pops return 0x11..0x15 in order.
- DEPTH=5: run 12 push/pop pairs sustained while used=2 -> used stays 2; pointers wrap 4->0 correctly; data order preserved.
- Empty FIFO: push 0xA5 at cycle N -> rd_valid=1 and rd_data=0xA5 at N+1, not at N.
- afull_thresh=4, aempty_thresh=1: fill 0..5 entries -> almost_empty=1 for used<=1; almost_full=1 for used>=4.
- 3 entries stored, clear asserted together with wr_valid -> next cycle used=0, empty=1, hwm=0; the write is dropped.
- With NX_FIFO_PARITY_EN: push 0x3C, force-flip stored bit 2, pop -> parity_err pulses 1 cycle after pop; sticky stays 1 until clear.
